// File: rtl/alu_pkg.sv
// Shared ALU definitions. Holds only the multiplier state encoding.
package alu_pkg;

  localparam int MUL_STATE_W = 2;

  typedef enum logic [MUL_STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage : alu_pkg

// File: rtl/nbit_full_adder.sv
// Ripple-carry adder over WIDTH+1 bits; the accumulation datapath of the ALU.
module nbit_full_adder #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           ci,
  output logic [WIDTH:0] s,
  output logic           co
);

  logic [WIDTH+1:0] carry;

  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = ci;
    for (int i = 0; i <= WIDTH; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    co = carry[WIDTH+1];
  end

endmodule : nbit_full_adder

// File: rtl/seq_mul_unit.sv
// Unsigned shift-and-add multiplier: one adder pass per cycle, N iterations,
// registered double-width product with zero/overflow flags.
module seq_mul_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH:0]     a,
  input  logic [WIDTH:0]     b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH+1:0] product,
  output logic               zero,
  output logic               ovf
);

  localparam int N  = WIDTH + 1;
  localparam int CW = $clog2(N + 1);

  mul_state_t state_q, state_d;

  logic [N-1:0]   acc_q,   acc_d;
  logic [N-1:0]   mq_q,    mq_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] product_q, product_d;
  logic           zero_q,  zero_d;
  logic           ovf_q,   ovf_d;

  logic [N-1:0]   add_b;
  logic [N-1:0]   add_s;
  logic           add_co;
  logic [N-1:0]   acc_nx;
  logic [N-1:0]   mq_nx;
  logic           last_iter;

  nbit_full_adder #(.WIDTH(WIDTH)) u_adder (
    .a  (acc_q),
    .b  (add_b),
    .ci (1'b0),
    .s  (add_s),
    .co (add_co)
  );

  assign add_b     = mq_q[0] ? mcand_q : '0;
  assign last_iter = (count_q == CW'(N - 1));

  // {c, acc, mq} >> 1 over 2N+1 bits: the top bit always shifts to zero, so
  // only the low 2N bits are kept and the carry lands in acc's MSB.
  assign {acc_nx, mq_nx} = {add_co, add_s, mq_q[N-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // NOTE: every _d signal is defaulted to its register first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_d     = acc_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          mq_d    = b;
          acc_d   = '0;
          count_d = '0;
        end
      end
      RUN: begin
        acc_d   = acc_nx;
        mq_d    = mq_nx;
        count_d = count_q + CW'(1);
        if (last_iter) begin
          product_d = {acc_nx, mq_nx};
          zero_d    = ({acc_nx, mq_nx} == '0);
          ovf_d     = |acc_nx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mq_q      <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
    end
  end

  assign product = product_q;
  assign zero    = zero_q;
  assign ovf     = ovf_q;

endmodule : seq_mul_unit
